// File: rtl/multi_chan_delay_timer_if.sv
// Bundled control/status signals of the multi-channel delay timer.
// The master side drives enables and period writes; the slave side is the timer.
interface multi_chan_delay_timer_if #(
    parameter int NCH   = 4,
    parameter int CBITS = 14
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]   en;
    logic [NCH-1:0]   periodic;
    logic             prd_we;
    logic [CHW-1:0]   prd_ch;
    logic [CBITS-1:0] prd_val;
    logic [NCH-1:0]   err_clr;
    logic [NCH-1:0]   sig;
    logic [NCH-1:0]   flg;
    logic [NCH-1:0]   err;
    logic             any_sig;

    modport master (
        output en, periodic, prd_we, prd_ch, prd_val, err_clr,
        input  sig, flg, err, any_sig
    );

    modport slave (
        input  en, periodic, prd_we, prd_ch, prd_val, err_clr,
        output sig, flg, err, any_sig
    );
endinterface

// File: rtl/multi_chan_delay_timer.sv
// NCH independent IDLE/RUN/DONE delay counters with programmable period, one-shot/periodic
// reload, in-window flag and sticky error. Define DELAY_TIMER_SVA_EN to compile in assertions.
module multi_chan_delay_timer #(
    parameter int NCH   = 4,
    parameter int CBITS = 14,
    parameter int N     = 10000
) (
    input  logic                    clk,
    input  logic                    rst,
    multi_chan_delay_timer_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CBITS-1:0] PRD_RST = CBITS'(N);
    localparam logic [CBITS:0]   ONE_W   = (CBITS+1)'(1);

    logic [1:0]       state_q  [NCH];
    logic [1:0]       state_d  [NCH];
    logic [CBITS-1:0] cnt_q    [NCH];
    logic [CBITS-1:0] cnt_d    [NCH];
    logic [CBITS-1:0] period_q [NCH];
    logic [CBITS-1:0] period_d [NCH];
    logic [CBITS:0]   c_w      [NCH];
    logic [NCH-1:0]   wr_hit;
    logic [NCH-1:0]   sig_q, sig_d;
    logic [NCH-1:0]   flg_q, flg_d;
    logic [NCH-1:0]   err_q, err_d;
    logic             any_q, any_d;

    always_comb begin
        any_d = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            // Out-of-range channel numbers match no channel, so such writes vanish.
            wr_hit[i]   = bus.prd_we && (int'(bus.prd_ch) == i);
            c_w[i]      = {1'b0, cnt_q[i]} + ONE_W;
            state_d[i]  = state_q[i];
            cnt_d[i]    = cnt_q[i];
            period_d[i] = wr_hit[i] ? bus.prd_val : period_q[i];
            sig_d[i]    = 1'b0;
            err_d[i]    = err_q[i] & ~bus.err_clr[i];

            case (state_q[i])
                S_IDLE: begin
                    cnt_d[i] = '0;
                    if (bus.en[i]) state_d[i] = S_RUN;
                end
                S_RUN: begin
                    if (!bus.en[i]) begin
                        state_d[i] = S_IDLE;
                        cnt_d[i]   = '0;
                    end else if (c_w[i] > {1'b0, period_q[i]}) begin
                        // Expiry is judged against the period in force before any write this cycle.
                        sig_d[i] = 1'b1;
                        cnt_d[i] = '0;
                        if (!bus.periodic[i]) state_d[i] = S_DONE;
                    end else begin
                        cnt_d[i] = c_w[i][CBITS-1:0];
                    end
                end
                S_DONE: begin
                    cnt_d[i] = '0;
                    if (!bus.en[i]) state_d[i] = S_IDLE;
                end
                default: begin
                    state_d[i] = S_IDLE;
                    cnt_d[i]   = '0;
                end
            endcase

            // Shrinking the period below the running count is flagged; set beats clear.
            if (wr_hit[i] && (state_q[i] == S_RUN) && (bus.prd_val < cnt_q[i]))
                err_d[i] = 1'b1;

            flg_d[i] = (state_d[i] == S_RUN) && (cnt_d[i] <= period_d[i]);
            any_d    = any_d | sig_d[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i]  <= S_IDLE;
                cnt_q[i]    <= '0;
                period_q[i] <= PRD_RST;
            end
            sig_q <= '0;
            flg_q <= '0;
            err_q <= '0;
            any_q <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i]  <= state_d[i];
                cnt_q[i]    <= cnt_d[i];
                period_q[i] <= period_d[i];
            end
            sig_q <= sig_d;
            flg_q <= flg_d;
            err_q <= err_d;
            any_q <= any_d;
        end
    end

    assign bus.sig     = sig_q;
    assign bus.flg     = flg_q;
    assign bus.err     = err_q;
    assign bus.any_sig = any_q;

`ifdef DELAY_TIMER_SVA_EN
    for (genvar g = 0; g < NCH; g++) begin : g_sva
        a_no_double_sig : assert property (@(posedge clk) disable iff (rst)
            (sig_q[g] && (period_q[g] != '0)) |=> !sig_q[g]);

        a_err_cause : assert property (@(posedge clk) disable iff (rst)
            $rose(err_q[g]) |-> $past(bus.prd_we && (int'(bus.prd_ch) == g)));

        a_liveness : assert property (@(posedge clk) disable iff (rst)
            (bus.en[g] && (state_q[g] == S_IDLE)) |-> s_eventually (sig_q[g] || !bus.en[g]));

        a_flg_until_sig : assert property (@(posedge clk) disable iff (rst)
            ((state_q[g] == S_RUN) && ($past(state_q[g]) != S_RUN))
            |-> (flg_q[g] s_until (sig_q[g] || !bus.en[g] || err_q[g])));
    end
`else
`endif
endmodule
